// File: rtl/mipi_lane_deskew.sv
// Multi-lane start-of-burst deskew for the DSI receive path.
// Measures per-lane arrival offsets, then taps each lane's delay line so all enabled lanes leave aligned.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | track lane_en, wait for the first enabled lane to go valid
//   S_WAIT   | collect arrivals of the remaining enabled lanes
//   S_LOCKED | stream tapped, aligned bytes while every tapped valid is high
//   S_DRAIN  | wait for all enabled raw validin to fall before re-arming
module mipi_lane_deskew #(
    parameter int LANES    = 4,
    parameter int MAX_SKEW = 3,
    localparam int CW      = $clog2(MAX_SKEW + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES-1:0]   lane_en,
    input  logic [8*LANES-1:0] din,
    input  logic [LANES-1:0]   validin,
    output logic [8*LANES-1:0] dout,
    output logic               validout,
    output logic               error,
    output logic [CW-1:0]      skew
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_LOCKED,
        S_DRAIN
    } state_t;

    state_t state;

    logic [LANES-1:0] en_q;
    logic [LANES-1:0] arrived;
    logic [CW-1:0]    arr [LANES];
    logic [CW-1:0]    dly [LANES];
    logic [CW-1:0]    cnt;
    logic             armed;

    logic [7:0] sr_d [LANES][MAX_SKEW+1];
    logic       sr_v [LANES][MAX_SKEW+1];

    logic [LANES-1:0]   en_cur;
    logic [LANES-1:0]   vin_en;
    logic [LANES-1:0]   arr_now;
    logic               all_arr;
    logic [LANES-1:0]   tap_v;
    logic               tap_and;
    logic [8*LANES-1:0] tap_word;

    // In IDLE the live mask decides what counts as a start; afterwards the latched mask rules.
    always_comb begin
        en_cur   = (state == S_IDLE) ? lane_en : en_q;
        vin_en   = validin & en_cur;
        arr_now  = arrived | vin_en;
        all_arr  = &(arr_now | ~en_cur);
        tap_v    = '0;
        tap_word = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k <= MAX_SKEW; k++) begin
                if (dly[i] == CW'(k)) begin
                    tap_v[i] = sr_v[i][k];
                    if (en_q[i])
                        tap_word[8*i +: 8] = sr_d[i][k];
                end
            end
        end
        tap_and = &(tap_v | ~en_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            en_q     <= '0;
            arrived  <= '0;
            cnt      <= '0;
            armed    <= 1'b0;
            dout     <= '0;
            validout <= 1'b0;
            error    <= 1'b0;
            skew     <= '0;
            for (int i = 0; i < LANES; i++) begin
                arr[i] <= '0;
                dly[i] <= '0;
                for (int k = 0; k <= MAX_SKEW; k++) begin
                    sr_d[i][k] <= '0;
                    sr_v[i][k] <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                sr_d[i][0] <= din[8*i +: 8];
                sr_v[i][0] <= validin[i];
                for (int k = 1; k <= MAX_SKEW; k++) begin
                    sr_d[i][k] <= sr_d[i][k-1];
                    sr_v[i][k] <= sr_v[i][k-1];
                end
            end

            validout <= 1'b0;
            error    <= 1'b0;

            case (state)
                S_IDLE: begin
                    en_q <= lane_en;
                    // armed blocks lanes that were already mid-burst (e.g. after reset) from locking
                    if (vin_en == '0) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed   <= 1'b0;
                        arrived <= vin_en;
                        for (int i = 0; i < LANES; i++)
                            arr[i] <= '0;
                        if (all_arr) begin
                            state <= S_LOCKED;
                            skew  <= '0;
                            for (int i = 0; i < LANES; i++)
                                dly[i] <= '0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CW'(1);
                        end
                    end
                end

                S_WAIT: begin
                    arrived <= arr_now;
                    for (int i = 0; i < LANES; i++)
                        if (vin_en[i] && !arrived[i])
                            arr[i] <= cnt;
                    if (all_arr) begin
                        state <= S_LOCKED;
                        skew  <= cnt;
                        for (int i = 0; i < LANES; i++)
                            dly[i] <= arrived[i] ? cnt - arr[i] : '0;
                    end else if (cnt >= CW'(MAX_SKEW)) begin
                        error <= 1'b1;
                        state <= S_DRAIN;
                    end else if (cnt < CW'(MAX_SKEW + 1)) begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_LOCKED: begin
                    if (tap_and) begin
                        validout <= 1'b1;
                        dout     <= tap_word;
                    end else begin
                        dout  <= '0;
                        state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (vin_en == '0) begin
                        state   <= S_IDLE;
                        arrived <= '0;
                        cnt     <= '0;
                        armed   <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_lane_deskew.sv
// Directed bench for mipi_lane_deskew: a history-based burst model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_mipi_lane_deskew;

    localparam int LANES    = 4;
    localparam int MAX_SKEW = 3;
    localparam int CW       = $clog2(MAX_SKEW + 2);
    localparam int HIST     = 1024;

    logic                clk;
    logic                rst;
    logic [LANES-1:0]    lane_en;
    logic [8*LANES-1:0]  din;
    logic [LANES-1:0]    validin;
    logic [8*LANES-1:0]  dout;
    logic                validout;
    logic                error;
    logic [CW-1:0]       skew;

    mipi_lane_deskew #(.LANES(LANES), .MAX_SKEW(MAX_SKEW)) dut (
        .clk      (clk),
        .rst      (rst),
        .lane_en  (lane_en),
        .din      (din),
        .validin  (validin),
        .dout     (dout),
        .validout (validout),
        .error    (error),
        .skew     (skew)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: remembers every input byte; once locked, output word j is each lane's
    // (first-arrival + j)-th byte, valid while every enabled lane still had valid there.
    localparam int P_IDLE = 0, P_COLLECT = 1, P_STREAM = 2, P_DRAIN = 3;
    logic       hv [LANES][HIST];
    logic [7:0] hd [LANES][HIST];
    int         first_c [LANES];
    int         cyc = 0;
    int         ph = P_IDLE;
    int         t0 = 0;
    int         j = 0;
    bit         armed = 0;
    bit         live = 0;
    bit         ok;
    logic [LANES-1:0] m_en = '0;
    logic             m_vout, m_err;
    logic [31:0]      m_dout;
    logic [CW-1:0]    m_skew = '0;

    function automatic bit all_arrived();
        for (int i = 0; i < LANES; i++)
            if (m_en[i] && first_c[i] < 0) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (cyc < HIST)
            for (int i = 0; i < LANES; i++) begin
                hv[i][cyc] = validin[i];
                hd[i][cyc] = din[8*i +: 8];
            end
        m_vout = 1'b0;
        m_err  = 1'b0;
        m_dout = '0;
        if (!rst) begin
            ph = P_IDLE; armed = 0; m_skew = '0; live = 1;
        end else begin
            case (ph)
                P_IDLE: begin
                    m_en = lane_en;
                    if ((validin & lane_en) == '0) armed = 1;
                    else if (armed) begin
                        armed = 0;
                        t0 = cyc;
                        for (int i = 0; i < LANES; i++)
                            first_c[i] = (validin[i] && lane_en[i]) ? cyc : -1;
                        if (all_arrived()) begin
                            m_skew = '0; j = 0; ph = P_STREAM;
                        end else ph = P_COLLECT;
                    end
                end
                P_COLLECT: begin
                    for (int i = 0; i < LANES; i++)
                        if (m_en[i] && first_c[i] < 0 && validin[i]) first_c[i] = cyc;
                    if (all_arrived()) begin
                        m_skew = CW'(cyc - t0); j = 0; ph = P_STREAM;
                    end else if (cyc - t0 >= MAX_SKEW) begin
                        m_err = 1'b1; ph = P_DRAIN;
                    end
                end
                P_STREAM: begin
                    ok = 1;
                    for (int i = 0; i < LANES; i++)
                        if (m_en[i]) begin
                            if (!hv[i][first_c[i] + j]) ok = 0;
                            else m_dout[8*i +: 8] = hd[i][first_c[i] + j];
                        end
                    if (ok) begin
                        m_vout = 1'b1; j++;
                    end else begin
                        m_dout = '0; ph = P_DRAIN;
                    end
                end
                default: begin
                    if ((validin & m_en) == '0) begin
                        ph = P_IDLE; armed = 1;
                    end
                end
            endcase
        end
        cyc++;
        #1;
        if (live) begin
            chk("validout", {31'b0, validout}, {31'b0, m_vout});
            chk("error", {31'b0, error}, {31'b0, m_err});
            chk("skew", {29'b0, skew}, {29'b0, m_skew});
            if (m_vout) chk("dout", dout, m_dout);
        end
    end

    // Burst driver: per-lane offset/length/first byte, garbage toggling for chosen lanes,
    // optional reset cycle; records outputs seen after each edge into obs_*.
    int         b_off [LANES];
    int         b_len [LANES];
    logic [7:0] b_base [LANES];
    bit         b_garb [LANES];
    int         b_total;
    int         b_rst_at;
    logic       obs_v [64];
    logic       obs_e [64];
    logic [31:0] obs_d [64];
    logic [CW-1:0] obs_s [64];

    task automatic burst();
        for (int k = 0; k < b_total; k++) begin
            for (int i = 0; i < LANES; i++) begin
                if (b_garb[i]) begin
                    validin[i]     = ((k + i) % 2) == 1;
                    din[8*i +: 8]  = 8'h5A + 8'(k);
                end else if (k >= b_off[i] && k < b_off[i] + b_len[i]) begin
                    validin[i]     = 1'b1;
                    din[8*i +: 8]  = b_base[i] + 8'(k - b_off[i]);
                end else begin
                    validin[i]     = 1'b0;
                    din[8*i +: 8]  = 8'hEE;
                end
            end
            rst = (k == b_rst_at) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            obs_v[k] = validout;
            obs_e[k] = error;
            obs_d[k] = dout;
            obs_s[k] = skew;
            #1;
        end
        validin = '0;
        din     = '0;
        rst     = 1'b1;
    endtask

    task automatic idle(input int n);
        validin = '0;
        din     = '0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic setup(input int o0, o1, o2, o3, input int l0, l1, l2, l3,
                         input logic [31:0] bases, input int total);
        b_off[0] = o0; b_off[1] = o1; b_off[2] = o2; b_off[3] = o3;
        b_len[0] = l0; b_len[1] = l1; b_len[2] = l2; b_len[3] = l3;
        for (int i = 0; i < LANES; i++) begin
            b_base[i] = bases[8*i +: 8];
            b_garb[i] = 0;
        end
        b_total  = total;
        b_rst_at = -1;
    endtask

    function automatic int sum_v(input int n);
        int s = 0;
        for (int k = 0; k < n; k++) s += int'(obs_v[k]);
        return s;
    endfunction

    function automatic int sum_e(input int n);
        int s = 0;
        for (int k = 0; k < n; k++) s += int'(obs_e[k]);
        return s;
    endfunction

    initial begin
        rst = 1'b0; lane_en = 4'hF; validin = '0; din = '0;
        @(posedge clk); #2;
        @(posedge clk); #1;
        chk("reset_validout", {31'b0, validout}, 32'd0);
        chk("reset_error", {31'b0, error}, 32'd0);
        chk("reset_dout", dout, 32'd0);
        chk("reset_skew", {29'b0, skew}, 32'd0);
        #1;
        rst = 1'b1;
        idle(3);

        // all lanes aligned
        setup(0, 0, 0, 0, 8, 8, 8, 8, 32'h40302010, 12);
        burst();
        chk("aligned_no_early_valid", {31'b0, obs_v[0]}, 32'd0);
        chk("aligned_validout", {31'b0, obs_v[1]}, 32'd1);
        chk("aligned_dout", obs_d[1], 32'h40302010);
        chk("aligned_skew", {29'b0, obs_s[1]}, 32'd0);
        chk("aligned_len", sum_v(12), 32'd8);
        idle(3);

        // offsets 0,1,3,2, 16-byte burst
        setup(0, 1, 3, 2, 16, 16, 16, 16, 32'hA3A2A1A0, 24);
        burst();
        chk("skew3_before", {31'b0, obs_v[3]}, 32'd0);
        chk("skew3_first_dout", obs_d[4], 32'hA3A2A1A0);
        chk("skew3_skew", {29'b0, obs_s[4]}, 32'd3);
        chk("skew3_last_dout", obs_d[19], 32'hB2B1B0AF);
        chk("skew3_len", sum_v(24), 32'd16);
        idle(3);

        // lane 3 at offset 4 -> error, then a clean burst
        setup(0, 0, 0, 4, 6, 6, 6, 6, 32'h0, 14);
        burst();
        chk("err_pulse_at", {31'b0, obs_e[3]}, 32'd1);
        chk("err_pulse_count", sum_e(14), 32'd1);
        chk("err_no_valid", sum_v(14), 32'd0);
        setup(1, 1, 1, 1, 4, 4, 4, 4, 32'h80706050, 8);
        burst();
        chk("after_err_dout", obs_d[2], 32'h80706050);
        chk("after_err_valid", {31'b0, obs_v[2]}, 32'd1);
        idle(3);

        // only lanes 0/1 enabled, 2/3 toggle garbage
        lane_en = 4'b0011;
        idle(2);
        setup(0, 1, 0, 0, 8, 8, 0, 0, 32'h0000C1C0, 14);
        b_garb[2] = 1; b_garb[3] = 1;
        burst();
        chk("mask_dout", obs_d[2], 32'h0000C1C0);
        chk("mask_skew", {29'b0, obs_s[2]}, 32'd1);
        chk("mask_len", sum_v(14), 32'd8);
        lane_en = 4'hF;
        idle(3);

        // lane 0 ends 3 cycles early, second burst 5 cycles later
        setup(0, 0, 0, 0, 5, 8, 8, 8, 32'h30201000, 13);
        burst();
        chk("early_end_len", sum_v(13), 32'd5);
        chk("early_end_no_err", sum_e(13), 32'd0);
        setup(0, 2, 1, 0, 6, 6, 6, 6, 32'h90807060, 10);
        burst();
        chk("second_dout", obs_d[3], 32'h90807060);
        chk("second_skew", {29'b0, obs_s[3]}, 32'd2);
        idle(3);

        // reset while locked
        setup(0, 0, 1, 0, 10, 10, 10, 10, 32'h0D0C0B0A, 14);
        b_rst_at = 3;
        burst();
        chk("pre_rst_valid", {31'b0, obs_v[2]}, 32'd1);
        chk("pre_rst_skew", {29'b0, obs_s[2]}, 32'd1);
        chk("rst_validout", {31'b0, obs_v[3]}, 32'd0);
        chk("rst_dout", obs_d[3], 32'd0);
        chk("rst_skew", {29'b0, obs_s[3]}, 32'd0);
        chk("rst_no_relock", sum_v(14) - 1, 32'd0);
        setup(0, 1, 0, 0, 4, 4, 4, 4, 32'h44332211, 8);
        burst();
        chk("post_rst_dout", obs_d[2], 32'h44332211);
        chk("post_rst_skew", {29'b0, obs_s[2]}, 32'd1);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mipi_lane_deskew.md
# mipi_lane_deskew

Parametrised multi-lane deskew stage for the DSI receive path. It sits between the per-lane byte aligners and the packet slicer, and replaces the fixed 4-lane aligner. It accepts 1..LANES lanes, enabled by a runtime mask, with per-lane arrival skew up to MAX_SKEW byte-clock cycles. It reports the measured skew and flags bursts whose skew exceeds the window.

## Interface
- LANES, 4: physical lane count (1..8).
- MAX_SKEW, 3: largest tolerated start-of-burst skew between enabled lanes, in cycles (1..15).
- CW, derived = $clog2(MAX_SKEW+2): counter/skew width.

Ports:
- clk  in  1  byte clock (gclk domain); single clock.
- rst  in  1  synchronous, active-low reset.
- lane_en  in  LANES  lane enable mask; sampled only in IDLE.
- din  in  8*LANES  byte-aligned data; lane i at [8i+7:8i].
- validin  in  LANES  per-lane byte-valid from the byte aligners; high for the whole burst.
- dout  out  8*LANES  deskewed data; disabled lanes forced to 0.
- validout  out  1  all enabled lanes aligned, dout valid.
- error  out  1  one-cycle pulse when the skew window is exceeded.
- skew  out  CW  spread (last minus first arrival) of the most recent locked burst.

## Operation
- Each lane has a delay line of MAX_SKEW+1 byte/valid entries. sr_i[k] holds din_i/validin_i from k+1 cycles ago.
- States: IDLE, WAIT, LOCKED, DRAIN.
- IDLE:
  - Latch lane_en into en_q every cycle.
  - On the first cycle any enabled validin is high (cycle T0), record arrival 0 for every enabled lane high in that cycle.
  - Set cnt=0 and go to WAIT. If all enabled lanes are already high at T0, go straight to lock (see below).
  - en_q==0: remain in IDLE.
- WAIT:
  - cnt increments each cycle. Each enabled lane's first validin-high cycle records arrival a_i = cnt.
  - When all enabled lanes have arrived (at cycle T, cnt=c): set delay_i = c - a_i, skew = c, and go to LOCKED.
  - If cnt==MAX_SKEW and lanes are still missing after that cycle's arrivals: error=1 next cycle, go to DRAIN.
  - Arrival exactly MAX_SKEW after the first lane is accepted.
- LOCKED:
  - Lane i output byte = sr_i[delay_i]; lane valid = sr_i[delay_i].valid.
  - validout = AND of the tapped valids of enabled lanes.
  - Once that AND falls, validout goes low and the block moves to DRAIN. A lane ending early is not an error.
- DRAIN: wait until all enabled raw validin are low, then go to IDLE. Arrival flags are cleared.
- A lane that deasserts during WAIT before lock keeps its recorded arrival. Its tapped valid is then low in LOCKED, so the burst ends immediately.
- Disabled lanes: their validin is ignored, their dout byte is 0, and they are excluded from all ANDs.
- skew and delay_i hold their values until the next lock. error never asserts in the same cycle as validout.

## Timing
- Reset (rst low at a clk edge):
  - Next cycle: state=IDLE, validout=0, error=0, dout=0, skew=0, delay lines and flags cleared.
  - Reset mid-LOCKED ends the burst with no further output.
- Latency: the last lane's first byte at cycle T appears on dout with validout=1 at T+2. The first dout word contains the first byte of every enabled lane.
- validout stays high for N consecutive cycles, where N is the length of the shortest tapped burst.
- Error timing: first arrival at T0 and a lane still missing at T0+MAX_SKEW gives error high at T0+MAX_SKEW+1 for exactly one cycle.
- A new burst is recognised no earlier than one cycle after DRAIN sees all validin low.
- cnt saturates at MAX_SKEW+1 and never wraps.

## Test plan
- LANES=4, MAX_SKEW=3, en=4'hF; all lanes rise at T with bytes 0x10,0x20,0x30,0x40 (lane0..3) -> at T+2 validout=1, dout=0x40302010, skew=0.
- Lane arrival offsets 0,1,3,2 (lanes 0..3), each lane's first byte 0xA0+i -> at T0+5 dout=0xA3A2A1A0, skew=3. Bytes stay aligned for the whole 16-byte burst, and validout lasts exactly 16 cycles.
- Lane 3 arrives at offset 4 -> error=1 only at T0+4, validout never asserts. After all validin go low the block returns to IDLE, and the next aligned burst locks normally.
- lane_en=4'b0011 with lanes 2/3 toggling garbage -> dout[31:16]=0. Lock depends only on lanes 0/1, which arrive 1 cycle apart -> skew=1.
- Lane 0 drops validin 3 cycles before the others -> validout falls when lane 0's tapped valid falls, error=0. A second burst 5 cycles later locks with its own fresh skew value.
- rst driven low for 1 cycle during LOCKED -> next cycle validout=0, dout=0, skew=0. Lanes still high after reset are not locked until they go low and start a fresh burst.
